axi_multi_logger: RTL

AXI_MULTI_LOGGER -- requirements
Module: axi_multi_logger

---
 rtl/axi_multi_logger_if.sv | 16 +
 rtl/axi_multi_logger.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_multi_logger_if.sv
// AXI address-channel handshake bundle observed by the multi-channel logger.
// The monitor side only listens, so the slave modport is input-only.
interface axi_multi_logger_if #(
  parameter int NUM_CH        = 2,
  parameter int AXI_ID_BITW   = 8,
  parameter int AXI_ADDR_BITW = 32
);
  logic [NUM_CH-1:0]               AxiValid_SI;
  logic [NUM_CH-1:0]               AxiReady_SI;
  logic [NUM_CH*AXI_ID_BITW-1:0]   AxiId_DI;
  logic [NUM_CH*AXI_ADDR_BITW-1:0] AxiAddr_DI;
  logic [NUM_CH*8-1:0]             AxiLen_DI;

  modport master (output AxiValid_SI, AxiReady_SI, AxiId_DI, AxiAddr_DI, AxiLen_DI);
  modport slave  (input  AxiValid_SI, AxiReady_SI, AxiId_DI, AxiAddr_DI, AxiLen_DI);
endinterface

// File: rtl/axi_multi_logger.sv
// Multi-channel AXI address logger: captures every handshake into a one-deep
// pending register per channel, round-robin drains them into a BRAM log,
// and supports stop-when-full or circular logging plus a zeroing clear sweep.
module axi_multi_logger #(
  parameter int NUM_CH          = 2,
  parameter int AXI_ID_BITW     = 8,
  parameter int AXI_ADDR_BITW   = 32,
  parameter int NUM_LOG_ENTRIES = 16384,
  parameter int FULL_MARGIN     = 1024
) (
  input  logic                                       Clk_CI,
  input  logic                                       Rst_RI,
  axi_multi_logger_if.slave                          i_axi,
  input  logic                                       Enable_SI,
  input  logic                                       Wrap_SI,
  input  logic                                       Clear_SI,
  output logic                                       WrEn_SO,
  output logic [$clog2(NUM_LOG_ENTRIES)-1:0]         WrAddr_DO,
  output logic [((64+AXI_ADDR_BITW+31)/32)*32-1:0]   WrData_DO,
  output logic                                       Full_SO,
  output logic                                       Wrapped_SO,
  output logic                                       Clearing_SO,
  output logic [15:0]                                DropCnt_DO
);

  localparam int DW = ((64 + AXI_ADDR_BITW + 31) / 32) * 32;
  localparam int AW = $clog2(NUM_LOG_ENTRIES);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_LOG_ENTRIES - 1);
  localparam logic [AW-1:0] FULL_THRESH = AW'(NUM_LOG_ENTRIES - FULL_MARGIN);

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FULL     = 2'd1,
    CLEARING = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [AW-1:0]     r_wrCnt;
  logic [AW-1:0]     w_wrCntNext;
  logic              r_wrapped;
  logic              w_wrappedNext;
  logic              w_wrEn;
  logic [31:0]       r_ts;
  logic [NUM_CH-1:0] r_pendValid;
  logic [DW-1:0]     r_pendData [NUM_CH];
  logic [CW-1:0]     r_lastGrant;
  logic [15:0]       r_dropCnt;

  logic [NUM_CH-1:0] w_axiHs;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_capture;
  logic [NUM_CH-1:0] w_drop;
  logic [DW-1:0]     w_entry [NUM_CH];
  logic              w_grantValid;
  logic [CW-1:0]     w_grantIdx;
  logic [2:0]        w_dropNum;
  logic [16:0]       w_dropSum;

  assign w_axiHs = i_axi.AxiValid_SI & i_axi.AxiReady_SI & {NUM_CH{Enable_SI}};

  // A channel may load its pending slot when it is empty or being drained this cycle.
  assign w_capture = (r_state == READY) ? (w_axiHs & (~r_pendValid | w_grant)) : '0;

  // Handshakes with nowhere to go are lost; in FULL every handshake is lost.
  assign w_drop = (r_state == READY) ? (w_axiHs & r_pendValid & ~w_grant) :
                  (r_state == FULL)  ? w_axiHs : '0;

  // Pack each channel's live handshake fields into a log entry.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_entry[c]                      = '0;
      w_entry[c][31:0]                = r_ts;
      w_entry[c][39:32]               = i_axi.AxiLen_DI[c*8 +: 8];
      w_entry[c][40 +: AXI_ID_BITW]   = i_axi.AxiId_DI[c*AXI_ID_BITW +: AXI_ID_BITW];
      w_entry[c][63:62]               = 2'(c);
      w_entry[c][64 +: AXI_ADDR_BITW] = i_axi.AxiAddr_DI[c*AXI_ADDR_BITW +: AXI_ADDR_BITW];
    end
  end

  // Round-robin pick of one pending channel, searching from the one after the last grant.
  always_comb begin
    logic [CW-1:0] idx;
    idx          = '0;
    w_grantValid = 1'b0;
    w_grantIdx   = r_lastGrant;
    w_grant      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CW'((int'(r_lastGrant) + i) % NUM_CH);
      if (!w_grantValid && r_pendValid[idx] && (r_state == READY)) begin
        w_grantValid = 1'b1;
        w_grantIdx   = idx;
      end
    end
    if (w_grantValid) begin
      w_grant[w_grantIdx] = 1'b1;
    end
  end

  // Number of channels losing a handshake this cycle, added onto the saturating counter.
  always_comb begin
    w_dropNum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_dropNum = w_dropNum + {2'b00, w_drop[c]};
    end
    w_dropSum = {1'b0, r_dropCnt} + {14'd0, w_dropNum};
  end

  // Next-state, write pointer and write strobe; a clear request overrides everything.
  always_comb begin
    w_stateNext   = r_state;
    w_wrCntNext   = r_wrCnt;
    w_wrappedNext = r_wrapped;
    w_wrEn        = 1'b0;
    case (r_state)
      READY: begin
        if (w_grantValid) begin
          w_wrEn      = 1'b1;
          w_wrCntNext = r_wrCnt + 1'b1;
          if (r_wrCnt == LAST_IDX) begin
            if (Wrap_SI) begin
              w_wrappedNext = 1'b1;
            end else begin
              w_stateNext = FULL;
            end
          end
        end
      end
      FULL: begin
      end
      CLEARING: begin
        w_wrEn      = 1'b1;
        w_wrCntNext = r_wrCnt + 1'b1;
        if (r_wrCnt == LAST_IDX) begin
          w_stateNext = READY;
        end
      end
      default: begin
        w_stateNext = READY;
      end
    endcase
    if (Clear_SI) begin
      w_stateNext   = CLEARING;
      w_wrCntNext   = '0;
      w_wrappedNext = 1'b0;
    end
  end

  // State, write pointer and wrapped flag registers.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state   <= READY;
      r_wrCnt   <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_wrCnt   <= w_wrCntNext;
      r_wrapped <= w_wrappedNext;
    end
  end

  // Free-running timestamp, wraps naturally at 32 bits.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
    end
  end

  // Pending slots: load on capture, empty when drained, flush on clear.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_pendValid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pendData[c] <= '0;
      end
    end else if (Clear_SI) begin
      r_pendValid <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_capture[c]) begin
          r_pendValid[c] <= 1'b1;
          r_pendData[c]  <= w_entry[c];
        end else if (w_grant[c]) begin
          r_pendValid[c] <= 1'b0;
        end
      end
    end
  end

  // Remember the last granted channel for round-robin fairness.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_lastGrant <= '0;
    end else if (w_grantValid) begin
      r_lastGrant <= w_grantIdx;
    end
  end

  // Saturating count of lost handshakes, zeroed by a clear.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_dropCnt <= '0;
    end else if (Clear_SI) begin
      r_dropCnt <= '0;
    end else if (w_dropSum[16]) begin
      r_dropCnt <= 16'hFFFF;
    end else begin
      r_dropCnt <= w_dropSum[15:0];
    end
  end

  assign WrEn_SO     = w_wrEn;
  assign WrAddr_DO   = r_wrCnt;
  assign WrData_DO   = w_grantValid ? r_pendData[w_grantIdx] : '0;
  assign Full_SO     = (r_state == FULL) |
                       ((r_state == READY) & ~Wrap_SI & (FULL_MARGIN > 0) &
                        (r_wrCnt >= FULL_THRESH));
  assign Wrapped_SO  = r_wrapped;
  assign Clearing_SO = (r_state == CLEARING);
  assign DropCnt_DO  = r_dropCnt;

endmodule
